test_data_serializer: RTL and testbench
=======================================

# test_data_serializer

- Upstream feeder for the logic-analyzer test harness: accepts parallel 8-bit test bytes from the avionics datapath, buffers them in a small FIFO, and shifts them out MSB-first.
- Outputs are a serial line (TEST_DATA) plus a generated bit clock (CLK_DOUT), which are exactly the inputs the harness consumes.
- Runs entirely in the 48 MHz domain; the bit rate is set by an integer divider.

## Interface
- DIV, 48, CLK_48MHZ cycles per serial bit; even, ≥4 (48 → 1 Mbit/s)
- FIFO_AW, 4, FIFO address width; depth = 2^FIFO_AW bytes
- SYNC_BYTE, 8'hA5, burst prefix byte (used only with TEST_HARNESS_SYNC_EN)
- CLK_48MHZ  in  1  system clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- DIN  in  8  byte to queue
- DIN_WR  in  1  write strobe, one byte per cycle high
- OVF_CLR  in  1  clears OVERFLOW
- CLK_DOUT  out  1  serial bit clock, registered; data stable on its rising edge
- TEST_DATA  out  1  serial data, MSB first, registered
- TEST_VALID  out  1  high while TEST_DATA carries a real bit
- FULL  out  1  FIFO full
- EMPTY  out  1  FIFO empty
- FIFO_LEVEL  out  FIFO_AW+1  bytes currently queued
- OVERFLOW  out  1  sticky; set when a write is dropped

## Operation
- FIFO: first-word-fall-through, 2^FIFO_AW × 8.
  - A write with DIN_WR=1 and FULL=0 is accepted.
  - A write while FULL=1 is dropped and sets OVERFLOW. FULL is the registered value; a write is dropped even if a pop occurs in the same cycle.
  - A simultaneous accepted write and pop leaves FIFO_LEVEL unchanged.
- Divider: div_cnt runs 0..DIV-1, free-running from reset and wrapping to 0. bit_tick = (div_cnt == DIV-1).
- CLK_DOUT: a flop. Its next value = (div_cnt_next ≥ DIV/2), so it falls when div_cnt becomes 0 and rises when div_cnt becomes DIV/2. It toggles continuously, including when idle.
- Serializer FSM, all transitions on bit_tick only:
  - IDLE:
    - If EMPTY=0: pop the FIFO head into shreg and enter SHIFT with bit_cnt=7.
    - Otherwise stay in IDLE.
  - SHIFT, on each bit_tick:
    - If bit_cnt>0: shift shreg left and decrement bit_cnt.
    - If bit_cnt==0 and EMPTY=0: pop the next byte back-to-back, with no gap bit, and set bit_cnt=7.
    - If bit_cnt==0 and EMPTY=1: go to IDLE.
- Outputs:
  - TEST_DATA = shreg[7] while in SHIFT; 0 in IDLE.
  - TEST_VALID = 1 while in SHIFT.
  - Both update on the edge where div_cnt becomes 0.
- Every serial bit lasts exactly DIV cycles, with the CLK_DOUT rising edge at the bit midpoint.

## Timing
- Reset values: div_cnt=0, CLK_DOUT=0, TEST_DATA=0, TEST_VALID=0, FIFO empty (EMPTY=1, FULL=0, FIFO_LEVEL=0), OVERFLOW=0, FSM=IDLE.
- A RESET asserted mid-byte aborts the byte, flushes the FIFO, and restarts the divider. Outputs reach their reset values on the next edge.
- Flags:
  - FULL, EMPTY and FIFO_LEVEL are registered and update the cycle after the write or pop.
  - OVERFLOW sets the cycle after a dropped write.
  - If OVF_CLR and a dropped write occur in the same cycle, the set wins.
- Latency, write into an empty FIFO while IDLE: the first bit appears on the edge after the next bit_tick. That is at least 1 and at most DIV cycles after the write, plus 1 cycle for the EMPTY update. A write on the bit_tick cycle itself is not seen until the following bit_tick.
- Sustained throughput: 1 byte per 8·DIV cycles. The FIFO never underflows, because pops only occur with EMPTY=0.
- Pop and the TEST_DATA update occur on the same edge.

## Configuration
- TEST_HARNESS_SYNC_EN defined:
  - On every IDLE→SHIFT start, SYNC_BYTE is serialized first. No FIFO pop happens at that start.
  - The FIFO byte follows back-to-back.
  - Back-to-back bytes within a burst get no additional sync.
  - TEST_VALID stays high during the sync byte.
- TEST_HARNESS_SYNC_EN undefined: there is no prefix; the SYNC_BYTE parameter is unused.

## Test plan
- Reset then idle for 100 cycles, DIV=8:
  - Outputs stay at reset values except CLK_DOUT.
  - CLK_DOUT is a clean square wave: 4 cycles low, 4 cycles high.
- Single byte, DIV=8, write 8'hC3:
  - TEST_DATA gives bits 1,1,0,0,0,0,1,1, each held 8 cycles, each stable at the CLK_DOUT rise.
  - TEST_VALID is high for exactly 64 cycles, then the FSM returns to IDLE.
- Back-to-back, write 8'h01, 8'h80, 8'hFF on consecutive cycles:
  - 24 contiguous bits with no gap bits.
  - FIFO_LEVEL goes 3→2→1→0 at byte boundaries.
- Overflow, FIFO_AW=2, write 6 bytes while the serializer is busy:
  - FULL asserts after 4 queued bytes.
  - The extra writes are dropped and OVERFLOW=1 until OVF_CLR.
  - The serialized stream contains only the accepted bytes, in order.
- Reset mid-byte, assert RESET at bit 3 of 8'hAA:
  - The next edge gives TEST_VALID=0, EMPTY=1, div_cnt=0.
  - A following write of 8'h55 serializes correctly from its MSB.
- With TEST_HARNESS_SYNC_EN, write 8'h3C:
  - Serial output is A5 then 3C (16 bits).
  - A second write after return to IDLE produces A5 again.

Source files
------------

// File: rtl/test_data_serializer.sv
// Byte FIFO feeding an MSB-first serializer with a divided bit clock for the logic-analyzer harness.
// Optional burst sync prefix: define TEST_HARNESS_SYNC_EN.
module test_data_serializer #(
  parameter int unsigned DIV       = 48,
  parameter int unsigned FIFO_AW   = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic               CLK_48MHZ,
  input  logic               RESET,
  input  logic [7:0]         DIN,
  input  logic               DIN_WR,
  input  logic               OVF_CLR,
  output logic               CLK_DOUT,
  output logic               TEST_DATA,
  output logic               TEST_VALID,
  output logic               FULL,
  output logic               EMPTY,
  output logic [FIFO_AW:0]   FIFO_LEVEL,
  output logic               OVERFLOW
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned LW    = FIFO_AW + 1;
  localparam int unsigned DW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2);
`ifdef TEST_HARNESS_SYNC_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [DW-1:0]      div_cnt;
  logic [DW-1:0]      div_cnt_next;
  logic               bit_tick;
  state_t             state;
  logic [2:0]         bit_cnt;
  logic [7:0]         shreg;
  logic               wr_acc;
  logic               pop;
  logic [7:0]         head;
  logic [7:0]         start_byte;
  logic [LW-1:0]      level_next;

  // Divider, FIFO bookkeeping and pop decision; pops only ever happen with EMPTY low.
  always_comb begin
    bit_tick     = (div_cnt == DIV_LAST);
    div_cnt_next = bit_tick ? '0 : div_cnt + DW'(1);
    head         = mem[rd_ptr];
    wr_acc       = DIN_WR && !FULL;
    pop          = 1'b0;
    if (bit_tick && !EMPTY) begin
      if (state == IDLE) pop = !SYNC_EN;
      else               pop = (bit_cnt == 3'd0);
    end
    start_byte = SYNC_EN ? SYNC_BYTE : head;
    level_next = FIFO_LEVEL + LW'(wr_acc) - LW'(pop);
  end

  always_ff @(posedge CLK_48MHZ) begin
    if (wr_acc) mem[wr_ptr] <= DIN;
  end

  // Bit clock and FIFO state; a dropped write outranks a same-cycle clear.
  always_ff @(posedge CLK_48MHZ) begin
    if (RESET) begin
      div_cnt    <= '0;
      CLK_DOUT   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      FIFO_LEVEL <= '0;
      FULL       <= 1'b0;
      EMPTY      <= 1'b1;
      OVERFLOW   <= 1'b0;
    end else begin
      div_cnt    <= div_cnt_next;
      CLK_DOUT   <= (div_cnt_next >= DIV_HALF);
      if (wr_acc) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)    rd_ptr <= rd_ptr + FIFO_AW'(1);
      FIFO_LEVEL <= level_next;
      FULL       <= (level_next == LW'(DEPTH));
      EMPTY      <= (level_next == '0);
      if (DIN_WR && FULL) OVERFLOW <= 1'b1;
      else if (OVF_CLR)   OVERFLOW <= 1'b0;
    end
  end

  // Serializer: state and outputs move only on bit_tick, so each bit spans DIV cycles.
  always_ff @(posedge CLK_48MHZ) begin
    if (RESET) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      TEST_DATA  <= 1'b0;
      TEST_VALID <= 1'b0;
    end else if (bit_tick) begin
      if (state == IDLE) begin
        if (!EMPTY) begin
          state      <= SHIFT;
          bit_cnt    <= 3'd7;
          shreg      <= start_byte;
          TEST_DATA  <= start_byte[7];
          TEST_VALID <= 1'b1;
        end
      end else begin
        if (bit_cnt != 3'd0) begin
          shreg     <= {shreg[6:0], 1'b0};
          bit_cnt   <= bit_cnt - 3'd1;
          TEST_DATA <= shreg[6];
        end else if (!EMPTY) begin
          shreg     <= head;
          bit_cnt   <= 3'd7;
          TEST_DATA <= head[7];
        end else begin
          state      <= IDLE;
          TEST_DATA  <= 1'b0;
          TEST_VALID <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_test_data_serializer.sv
// Bench for test_data_serializer: scoreboarded serial capture, table-driven byte and overflow vectors.
module tb_test_data_serializer;

  localparam int unsigned DIV     = 8;
  localparam int unsigned FIFO_AW = 2;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
`ifdef TEST_HARNESS_SYNC_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif
  localparam int unsigned SYNC_CYC = SYNC_EN ? 8 * DIV : 0;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       din = '0;
  logic             din_wr = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             clk_dout, test_data, test_valid, full, empty, overflow;
  logic [FIFO_AW:0] fifo_level;

  test_data_serializer #(.DIV(DIV), .FIFO_AW(FIFO_AW), .SYNC_BYTE(SYNC_BYTE)) dut (
    .CLK_48MHZ (clk),
    .RESET     (rst),
    .DIN       (din),
    .DIN_WR    (din_wr),
    .OVF_CLR   (ovf_clr),
    .CLK_DOUT  (clk_dout),
    .TEST_DATA (test_data),
    .TEST_VALID(test_valid),
    .FULL      (full),
    .EMPTY     (empty),
    .FIFO_LEVEL(fifo_level),
    .OVERFLOW  (overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard of bytes expected on the serial line, in order.
  logic [7:0] exp_q[$];

  task automatic push_burst_start();
    if (SYNC_EN) exp_q.push_back(SYNC_BYTE);
  endtask

  // Serial monitor on the falling system clock, away from the active edge.
  int         valid_run = 0;
  int         last_run  = 0;
  int         runs_done = 0;
  int         cap_n     = 0;
  int         mon_bytes = 0;
  logic [7:0] cap       = '0;
  logic       mon_prev_ck = 1'b0;
  logic       mon_prev_td = 1'b0;
  bit         mon_skip  = 1'b1;

  initial forever begin
    @(negedge clk);
    if (test_valid === 1'b1) begin
      valid_run++;
      if (clk_dout === 1'b1 && mon_prev_ck === 1'b0) begin
        cap = {cap[6:0], test_data};
        cap_n++;
        if (cap_n == 8) begin
          cap_n = 0;
          mon_bytes++;
          if (exp_q.size() == 0) check("unexpected_byte", {24'd0, cap}, 32'hFFFF_FFFF);
          else check("serial_byte", {24'd0, cap}, {24'd0, exp_q.pop_front()});
        end
      end
    end else begin
      if (valid_run != 0) begin
        last_run = valid_run;
        runs_done++;
      end
      valid_run = 0;
      cap_n = 0;
    end
    if (!mon_skip && test_data !== mon_prev_td)
      check("data_changes_on_clk_fall", {30'd0, mon_prev_ck, clk_dout}, 32'd2);
    mon_prev_ck = clk_dout;
    mon_prev_td = test_data;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    din = b;
    din_wr = 1'b1;
    tick();
    din_wr = 1'b0;
  endtask

  // Returns just after an edge on which CLK_DOUT fell, i.e. a bit_tick edge.
  task automatic wait_fall();
    logic prev;
    bit   found = 1'b0;
    for (int i = 0; i < 4 * DIV && !found; i++) begin
      prev = clk_dout;
      tick();
      if (prev === 1'b1 && clk_dout === 1'b0) found = 1'b1;
    end
    if (!found) check("wait_fall_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_run_end(input int runs0, input int budget);
    int n = 0;
    while (runs_done <= runs0 && n < budget) begin
      tick();
      n++;
    end
    if (runs_done <= runs0) check("run_end_timeout", 32'd0, 32'd1);
  endtask

  task automatic count_to_valid(input string name, input int exp);
    int n = 0;
    while (test_valid !== 1'b1 && n < 4 * DIV) begin
      tick();
      n++;
    end
    check(name, n, exp);
  endtask

  typedef struct {
    logic [7:0]  din;
    logic [7:0]  exp_byte;
    int unsigned exp_run;
  } single_t;

  typedef struct {
    logic [7:0] din;
    bit         accept;
    logic [2:0] exp_level;
    bit         exp_full;
    bit         exp_ovf;
  } ovf_t;

  single_t single_tbl[4];
  ovf_t    ovf_tbl[6];

  initial begin
    int          runs0;
    int          run_len;
    int          bad_idle;
    int          init_level;
    int          n;
    logic        cur;
    logic [2:0]  prev_lvl;
    logic [2:0]  lvl_seq[$];

    single_tbl[0] = '{8'hC3, 8'hC3, 64 + SYNC_CYC};
    single_tbl[1] = '{8'h00, 8'h00, 64 + SYNC_CYC};
    single_tbl[2] = '{8'hFF, 8'hFF, 64 + SYNC_CYC};
    single_tbl[3] = '{8'h5A, 8'h5A, 64 + SYNC_CYC};
`ifdef TEST_HARNESS_SYNC_EN
    init_level = 1;
    ovf_tbl[0] = '{8'h11, 1'b1, 3'd2, 1'b0, 1'b0};
    ovf_tbl[1] = '{8'h22, 1'b1, 3'd3, 1'b0, 1'b0};
    ovf_tbl[2] = '{8'h33, 1'b1, 3'd4, 1'b1, 1'b0};
    ovf_tbl[3] = '{8'h44, 1'b0, 3'd4, 1'b1, 1'b1};
    ovf_tbl[4] = '{8'h55, 1'b0, 3'd4, 1'b1, 1'b1};
    ovf_tbl[5] = '{8'h66, 1'b0, 3'd4, 1'b1, 1'b1};
`else
    init_level = 0;
    ovf_tbl[0] = '{8'h11, 1'b1, 3'd1, 1'b0, 1'b0};
    ovf_tbl[1] = '{8'h22, 1'b1, 3'd2, 1'b0, 1'b0};
    ovf_tbl[2] = '{8'h33, 1'b1, 3'd3, 1'b0, 1'b0};
    ovf_tbl[3] = '{8'h44, 1'b1, 3'd4, 1'b1, 1'b0};
    ovf_tbl[4] = '{8'h55, 1'b0, 3'd4, 1'b1, 1'b1};
    ovf_tbl[5] = '{8'h66, 1'b0, 3'd4, 1'b1, 1'b1};
`endif

    // Reset values.
    repeat (3) tick();
    check("rst_clk_dout", clk_dout, 0);
    check("rst_test_data", test_data, 0);
    check("rst_test_valid", test_valid, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    mon_skip = 1'b0;

    // Idle: outputs hold, CLK_DOUT is a DIV/2 square wave from the restart.
    bad_idle = 0;
    cur = clk_dout;
    run_len = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (test_valid !== 1'b0 || test_data !== 1'b0 || empty !== 1'b1 || full !== 1'b0 ||
          fifo_level !== '0 || overflow !== 1'b0) bad_idle++;
      if (clk_dout === cur) run_len++;
      else begin
        check("idle_clk_half_period", run_len, DIV / 2);
        cur = clk_dout;
        run_len = 1;
      end
    end
    check("idle_outputs_stable", bad_idle, 0);

    // Latency: write just after a bit_tick, then a write landing on the bit_tick itself.
    wait_fall();
    runs0 = runs_done;
    push_burst_start();
    exp_q.push_back(8'h96);
    write_byte(8'h96);
    count_to_valid("latency_after_tick", DIV - 1);
    wait_run_end(runs0, 400);
    check("latency_run_len", last_run, 64 + SYNC_CYC);

    wait_fall();
    repeat (DIV - 1) tick();
    runs0 = runs_done;
    push_burst_start();
    exp_q.push_back(8'h69);
    write_byte(8'h69);
    count_to_valid("latency_on_tick", DIV);
    wait_run_end(runs0, 400);
    check("latency_tick_run_len", last_run, 64 + SYNC_CYC);

    // Single bytes from the table.
    for (int i = 0; i < 4; i++) begin
      repeat (5) tick();
      runs0 = runs_done;
      push_burst_start();
      exp_q.push_back(single_tbl[i].exp_byte);
      write_byte(single_tbl[i].din);
      wait_run_end(runs0, 400);
      check("single_valid_cycles", last_run, single_tbl[i].exp_run);
      check("single_idle_data", test_data, 0);
      check("single_idle_empty", empty, 1);
    end

    // Back-to-back bytes: one contiguous burst, level steps down at byte boundaries.
    wait_fall();
    runs0 = runs_done;
    push_burst_start();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'hFF);
    write_byte(8'h01);
    write_byte(8'h80);
    write_byte(8'hFF);
    check("b2b_level_full", fifo_level, 3);
    prev_lvl = fifo_level;
    n = 0;
    while (runs_done <= runs0 && n < 800) begin
      tick();
      n++;
      if (fifo_level !== prev_lvl) begin
        lvl_seq.push_back(fifo_level);
        prev_lvl = fifo_level;
      end
    end
    if (runs_done <= runs0) check("b2b_timeout", 32'd0, 32'd1);
    check("b2b_level_changes", lvl_seq.size(), 3);
    for (int i = 0; i < 3; i++)
      check("b2b_level_step", (i < lvl_seq.size()) ? {29'd0, lvl_seq[i]} : 32'hFF, 2 - i);
    check("b2b_contiguous_cycles", last_run, 192 + SYNC_CYC);

    // Overflow while busy: only accepted bytes reach the line.
    repeat (5) tick();
    runs0 = runs_done;
    push_burst_start();
    exp_q.push_back(8'hF0);
    write_byte(8'hF0);
    n = 0;
    while (test_valid !== 1'b1 && n < 4 * DIV) begin
      tick();
      n++;
    end
    tick();
    check("ovf_init_level", fifo_level, init_level);
    for (int i = 0; i < 6; i++) begin
      if (ovf_tbl[i].accept) exp_q.push_back(ovf_tbl[i].din);
      write_byte(ovf_tbl[i].din);
      check("ovf_level", fifo_level, ovf_tbl[i].exp_level);
      check("ovf_full", full, ovf_tbl[i].exp_full);
      check("ovf_flag", overflow, ovf_tbl[i].exp_ovf);
    end
    din = 8'h77;
    din_wr = 1'b1;
    ovf_clr = 1'b1;
    tick();
    din_wr = 1'b0;
    ovf_clr = 1'b0;
    check("ovf_set_beats_clear", overflow, 1);
    check("ovf_dropped_level", fifo_level, 4);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 0);
    wait_run_end(runs0, 1000);
    check("ovf_stream_cycles", last_run, 320);
    check("ovf_drained_empty", empty, 1);

    // Reset mid-byte at bit 3 of AA, then a clean 55.
    repeat (5) tick();
    n = mon_bytes + (SYNC_EN ? 1 : 0);
    push_burst_start();
    exp_q.push_back(8'hAA);
    write_byte(8'hAA);
    for (int i = 0; i < 40 * DIV && !(mon_bytes == n && cap_n == 3); i++) tick();
    check("midbyte_reached_bit3", cap_n, 3);
    mon_skip = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", test_valid, 0);
    check("midrst_data", test_data, 0);
    check("midrst_empty", empty, 1);
    check("midrst_clk_dout", clk_dout, 0);
    exp_q.delete();
    n = 0;
    while (clk_dout !== 1'b1 && n < 2 * DIV) begin
      tick();
      n++;
    end
    check("midrst_div_restart", n, DIV / 2);
    tick();
    mon_skip = 1'b0;
    runs0 = runs_done;
    push_burst_start();
    exp_q.push_back(8'h55);
    write_byte(8'h55);
    wait_run_end(runs0, 400);
    check("post_rst_run_len", last_run, 64 + SYNC_CYC);

    repeat (4) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
